avg_window_unit: RTL

Parametrised averaging engine with valid/ready streaming on both sides. It computes the mean of a power-of-two window of unsigned samples, either as a non-overlapping block average or as a sliding (moving) average. The accumulator is overflow-free and the engine is controlled by a small FSM. It sits between a sample source and a consumer in the averaging datapath, replacing externally sequenced load/shift control with an internal handshake.

---
 rtl/avg_window_unit_if.sv | 26 ++
 rtl/avg_window_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/avg_window_unit_if.sv
// Streaming handshake bundle for avg_window_unit: control pulses, sample input
// channel and result output channel.
interface avg_window_unit_if #(
  parameter int W = 8
);
  logic         start;
  logic         stop;
  logic         mode;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;

  modport master (
    output start, stop, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, stop, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/avg_window_unit.sv
// Block / sliding mean over a 2^LOG2N window of unsigned samples with valid/ready on both sides.
// Optional AVG_WINDOW_ROUND_EN selects round-half-up results instead of truncation.
module avg_window_unit #(
  parameter int W     = 8,
  parameter int LOG2N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  avg_window_unit_if.slave bus
);

  localparam int N     = 1 << LOG2N;
  localparam int ACC_W = W + LOG2N;
  localparam int EXT_W = ACC_W + 1;
  localparam int CNT_W = (LOG2N > 0) ? LOG2N : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
`ifdef AVG_WINDOW_ROUND_EN
  localparam logic [EXT_W-1:0] HALF = EXT_W'(N >> 1);
`else
  localparam logic [EXT_W-1:0] HALF = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  // Window total to result; the extra headroom bit keeps total+HALF exact.
  function automatic logic [W-1:0] scale(input logic [EXT_W-1:0] total);
    scale = W'((total + HALF) >> LOG2N);
  endfunction

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wp_q, wp_d;
  logic [W-1:0]     win_q [N];
  logic [W-1:0]     win_d [N];
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;

  logic             in_ready_s;
  logic             accept_s;
  logic [CNT_W-1:0] wp_inc_s;
  logic [EXT_W-1:0] x_ext_s;
  logic [EXT_W-1:0] fill_total_s;
  logic [EXT_W-1:0] stream_total_s;

  assign in_ready_s = (state_q != S_IDLE) && (!out_valid_q || bus.out_ready)
                      && !bus.start && !bus.stop;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign wp_inc_s   = (wp_q == CNT_LAST) ? '0 : wp_q + CNT_W'(1);
  assign x_ext_s    = {{(EXT_W - W){1'b0}}, bus.in_data};

  // Sliding update drops the oldest sample, which sits at the write pointer.
  assign fill_total_s   = {1'b0, sum_q} + x_ext_s;
  assign stream_total_s = {1'b0, sum_q} + x_ext_s - {{(EXT_W - W){1'b0}}, win_q[wp_q]};

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != S_IDLE);

  // Next-state computation for the FSM, accumulator, sample window and output register.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    wp_d        = wp_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (bus.stop) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else if (bus.start) begin
      state_d     = S_FILL;
      mode_d      = bus.mode;
      sum_d       = '0;
      cnt_d       = '0;
      wp_d        = '0;
      out_valid_d = 1'b0;
      for (int i = 0; i < N; i++) begin
        win_d[i] = '0;
      end
    end else begin
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end

      if (accept_s) begin
        case (state_q)
          S_FILL: begin
            if (mode_q) begin
              win_d[wp_q] = bus.in_data;
              wp_d        = wp_inc_s;
            end else begin
              wp_d = wp_q;
            end
            if (cnt_q == CNT_LAST) begin
              out_valid_d = 1'b1;
              out_data_d  = scale(fill_total_s);
              cnt_d       = '0;
              if (mode_q) begin
                sum_d   = ACC_W'(fill_total_s);
                state_d = S_STREAM;
              end else begin
                sum_d   = '0;
                state_d = S_FILL;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              sum_d = ACC_W'(fill_total_s);
            end
          end
          S_STREAM: begin
            sum_d       = ACC_W'(stream_total_s);
            win_d[wp_q] = bus.in_data;
            wp_d        = wp_inc_s;
            out_valid_d = 1'b1;
            out_data_d  = scale(stream_total_s);
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      wp_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      wp_q        <= wp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < N; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

endmodule
